mk14_boot_ctrl: RTL

Sequencer for the MK14 SoC shared memory port and core reset. After reset it owns the MMU write port for the Intel-HEX loader, ends the load window on parse-complete or an RX inactivity timeout, and holds the core in reset for a fixed hold time. It then hands the port to the core and issues periodic refresh strobes to the TM1638 display engine. It replaces the ad-hoc wait/reset/run logic and address/data muxing in the SoC top level.

---
 rtl/mk14_boot_ctrl_if.sv | 47 ++++
 rtl/mk14_boot_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mk14_boot_ctrl_if.sv
// Purpose: bundles the loader, core, memory-port, display and status signals
//          of the MK14 boot sequencer.
// Ports (slave = sequencer side):
//   in : rx_byte_valid, ihex_data_valid, ihex_addr[15:0], ihex_data[7:0],
//        ihex_idle, ihex_error[2:0], ihex_parse_complete, core_addr[15:0],
//        core_write_en, core_write_data[7:0], display_idle, reload_req
//   out: mem_addr[15:0], mem_write_en, mem_write_data[7:0], rx_ready,
//        core_rst_n, display_en, state_o[1:0], load_error, bytes_loaded[15:0]
interface mk14_boot_ctrl_if;
    logic        rx_byte_valid;
    logic        ihex_data_valid;
    logic [15:0] ihex_addr;
    logic [7:0]  ihex_data;
    logic        ihex_idle;
    logic [2:0]  ihex_error;
    logic        ihex_parse_complete;
    logic [15:0] core_addr;
    logic        core_write_en;
    logic [7:0]  core_write_data;
    logic [15:0] mem_addr;
    logic        mem_write_en;
    logic [7:0]  mem_write_data;
    logic        rx_ready;
    logic        core_rst_n;
    logic        display_idle;
    logic        display_en;
    logic        reload_req;
    logic [1:0]  state_o;
    logic        load_error;
    logic [15:0] bytes_loaded;

    modport slave (
        input  rx_byte_valid, ihex_data_valid, ihex_addr, ihex_data, ihex_idle,
               ihex_error, ihex_parse_complete, core_addr, core_write_en,
               core_write_data, display_idle, reload_req,
        output mem_addr, mem_write_en, mem_write_data, rx_ready, core_rst_n,
               display_en, state_o, load_error, bytes_loaded
    );

    modport master (
        output rx_byte_valid, ihex_data_valid, ihex_addr, ihex_data, ihex_idle,
               ihex_error, ihex_parse_complete, core_addr, core_write_en,
               core_write_data, display_idle, reload_req,
        input  mem_addr, mem_write_en, mem_write_data, rx_ready, core_rst_n,
               display_en, state_o, load_error, bytes_loaded
    );
endinterface

// File: rtl/mk14_boot_ctrl.sv
// Purpose: MK14 boot sequencer. Owns the MMU write port for the Intel-HEX
//          loader during the load window, holds the core in reset for a fixed
//          time, then hands the port to the core and paces display refreshes.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mk14_boot_ctrl_if.slave (loader/core inputs, MMU port, status)
module mk14_boot_ctrl #(
    parameter int unsigned RX_TIMEOUT_CYCLES = 100000000,
    parameter int unsigned RX_EXTEND_CYCLES  = 5000000,
    parameter int unsigned REFRESH_CYCLES    = 2500000,
    parameter int unsigned RESET_HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mk14_boot_ctrl_if.slave   bus
);

    localparam int unsigned MAX_AB  = (RX_TIMEOUT_CYCLES > RX_EXTEND_CYCLES) ?
                                      RX_TIMEOUT_CYCLES : RX_EXTEND_CYCLES;
    localparam int unsigned MAX_CD  = (REFRESH_CYCLES > RESET_HOLD_CYCLES) ?
                                      REFRESH_CYCLES : RESET_HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(RX_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_EXTEND  = CNT_W'(RX_EXTEND_CYCLES);
    localparam logic [CNT_W-1:0] CNT_REFRESH = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RESET = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_load_error;
    logic [15:0]      r_bytes;
    logic             r_core_rst_n;
    logic             r_display_en;
    logic             r_rx_ready;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pending_nxt;
    logic             w_load_error_nxt;
    logic [15:0]      w_bytes_nxt;
    logic             w_display_en_nxt;
    logic             w_cnt_zero;
    logic             w_bytes_inc;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_bytes_inc = bus.ihex_data_valid && (r_bytes != 16'hFFFF);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD;
            r_cnt        <= CNT_TIMEOUT;
            r_pending    <= 1'b0;
            r_load_error <= 1'b0;
            r_bytes      <= 16'd0;
            r_core_rst_n <= 1'b0;
            r_display_en <= 1'b0;
            r_rx_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pending    <= w_pending_nxt;
            r_load_error <= w_load_error_nxt;
            r_bytes      <= w_bytes_nxt;
            r_core_rst_n <= (w_state_nxt == ST_RUN);
            r_display_en <= w_display_en_nxt;
            r_rx_ready   <= (w_state_nxt == ST_LOAD);
        end
    end

    // Next-state, shared counter and status updates
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pending_nxt    = r_pending;
        w_load_error_nxt = r_load_error;
        w_bytes_nxt      = r_bytes;
        w_display_en_nxt = 1'b0;

        case (r_state)
            ST_LOAD: begin
                // A received byte guarantees at least the extend window remains
                if (bus.rx_byte_valid && (r_cnt < CNT_EXTEND)) begin
                    w_cnt_nxt = CNT_EXTEND;
                end else if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
                if (w_bytes_inc) begin
                    w_bytes_nxt = r_bytes + 16'd1;
                end
                if (bus.ihex_error != 3'd0) begin
                    w_load_error_nxt = 1'b1;
                end
                if (bus.ihex_parse_complete || w_cnt_zero) begin
                    w_state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Let an in-flight record finish before taking the port away
                if (w_bytes_inc) begin
                    w_bytes_nxt = r_bytes + 16'd1;
                end
                if (bus.ihex_idle && !bus.ihex_data_valid) begin
                    w_state_nxt = ST_RESET;
                    w_cnt_nxt   = CNT_HOLD;
                end
            end

            ST_RESET: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_REFRESH;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            default: begin
                if (r_pending && bus.display_idle) begin
                    w_display_en_nxt = 1'b1;
                    w_pending_nxt    = 1'b0;
                end
                // Pending is a flag, so expiries while waiting collapse into one strobe
                if (w_cnt_zero) begin
                    w_cnt_nxt     = CNT_REFRESH;
                    w_pending_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
                if (bus.reload_req) begin
                    w_state_nxt      = ST_LOAD;
                    w_cnt_nxt        = CNT_TIMEOUT;
                    w_load_error_nxt = 1'b0;
                    w_bytes_nxt      = 16'd0;
                    w_pending_nxt    = 1'b0;
                    w_display_en_nxt = 1'b0;
                end
            end
        endcase
    end

    // Memory port mux, selected by the registered state
    always_comb begin
        bus.mem_addr       = bus.ihex_addr;
        bus.mem_write_en   = bus.ihex_data_valid;
        bus.mem_write_data = bus.ihex_data;
        case (r_state)
            ST_RESET: begin
                bus.mem_addr       = bus.core_addr;
                bus.mem_write_en   = 1'b0;
                bus.mem_write_data = bus.core_write_data;
            end
            ST_RUN: begin
                bus.mem_addr       = bus.core_addr;
                bus.mem_write_en   = bus.core_write_en;
                bus.mem_write_data = bus.core_write_data;
            end
            default: begin
                bus.mem_addr       = bus.ihex_addr;
                bus.mem_write_en   = bus.ihex_data_valid;
                bus.mem_write_data = bus.ihex_data;
            end
        endcase
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.core_rst_n   = r_core_rst_n;
    assign bus.display_en   = r_display_en;
    assign bus.state_o      = r_state;
    assign bus.load_error   = r_load_error;
    assign bus.bytes_loaded = r_bytes;

endmodule
